// File: rtl/polyunit_ntt_sched.sv
// Butterfly scheduler for the Kyber polynomial unit: sequences a 256-point NTT/INTT
// over the coefficient RAM and delays the issue addresses to the write-back port.
//
// state  | meaning
// S_IDLE   | waiting for a start with a legal mode
// S_RUN    | one butterfly issue per cycle for layer r_lyr
// S_DRAIN  | BFLAT idle cycles so the layer's last write lands
// S_SCALE  | INTT final scaling pass, 128 issues
// S_SDRAIN | BFLAT idle cycles after the scaling pass
// S_FIN    | done pulse, back to idle
module polyunit_ntt_sched #(
   parameter int ADDWID = 8,
   parameter int ZWID   = 7,
   parameter int BFLAT  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [1:0]        i_mode,
   output logic              o_rd_en,
   output logic [ADDWID-1:0] o_rd_addr_a,
   output logic [ADDWID-1:0] o_rd_addr_b,
   output logic [ZWID-1:0]   o_zeta_idx,
   output logic              o_bf_gs,
   output logic              o_scale_en,
   output logic              o_wr_en,
   output logic [ADDWID-1:0] o_wr_addr_a,
   output logic [ADDWID-1:0] o_wr_addr_b,
   output logic              o_busy,
   output logic              o_done
);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_SCALE, S_SDRAIN, S_FIN} state_t;

   typedef struct packed {
      logic [ADDWID-1:0] a;
      logic [ADDWID-1:0] b;
      logic [ZWID-1:0]   z;
   } issue_t;

   localparam logic [3:0] DRAIN_LD = 4'(BFLAT - 1);

   state_t     r_state;
   logic       r_intt;
   logic [2:0] r_lyr;
   logic [6:0] r_cnt;
   logic [3:0] r_tmr;

   // len is a power of two, so grp/off are a split of cnt at bit log2(len)
   function automatic issue_t f_issue(input logic intt, input logic scale,
                                      input logic [2:0] lyr, input logic [6:0] cnt);
      issue_t     r;
      logic [2:0] lg;
      logic [7:0] mask;
      logic [7:0] grp;
      logic [7:0] a;
      logic [7:0] z;
      lg   = intt ? lyr + 3'd1 : 3'd7 - lyr;
      mask = (8'd1 << lg) - 8'd1;
      grp  = {1'b0, cnt} >> lg;
      a    = (({1'b0, cnt} & ~mask) << 1) | ({1'b0, cnt} & mask);
      z    = intt ? (8'hFF >> lg) - grp : (8'd1 << lyr) + grp;
      if (scale) begin
         r.a = ADDWID'({1'b0, cnt});
         r.b = ADDWID'({1'b1, cnt});
         r.z = '0;
      end else begin
         r.a = ADDWID'(a);
         r.b = ADDWID'(a + mask + 8'd1);
         r.z = ZWID'(z);
      end
      return r;
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_intt      <= 1'b0;
         r_lyr       <= '0;
         r_cnt       <= '0;
         r_tmr       <= '0;
         o_rd_en     <= 1'b0;
         o_rd_addr_a <= '0;
         o_rd_addr_b <= '0;
         o_zeta_idx  <= '0;
         o_bf_gs     <= 1'b0;
         o_scale_en  <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         o_rd_en <= 1'b0;
         o_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start && i_mode[0]) begin
                  r_state    <= S_RUN;
                  r_intt     <= i_mode[1];
                  r_lyr      <= '0;
                  r_cnt      <= '0;
                  o_busy     <= 1'b1;
                  o_rd_en    <= 1'b1;
                  o_bf_gs    <= i_mode[1];
                  o_scale_en <= 1'b0;
                  {o_rd_addr_a, o_rd_addr_b, o_zeta_idx} <= f_issue(i_mode[1], 1'b0, 3'd0, 7'd0);
               end
            end
            S_RUN: begin
               if (r_cnt == 7'd127) begin
                  r_state <= S_DRAIN;
                  r_tmr   <= DRAIN_LD;
               end else begin
                  r_cnt   <= r_cnt + 7'd1;
                  o_rd_en <= 1'b1;
                  {o_rd_addr_a, o_rd_addr_b, o_zeta_idx} <= f_issue(r_intt, 1'b0, r_lyr, r_cnt + 7'd1);
               end
            end
            S_DRAIN: begin
               if (r_tmr != 4'd0) begin
                  r_tmr <= r_tmr - 4'd1;
               end else if (r_lyr != 3'd6) begin
                  r_state <= S_RUN;
                  r_lyr   <= r_lyr + 3'd1;
                  r_cnt   <= '0;
                  o_rd_en <= 1'b1;
                  {o_rd_addr_a, o_rd_addr_b, o_zeta_idx} <= f_issue(r_intt, 1'b0, r_lyr + 3'd1, 7'd0);
               end else if (r_intt) begin
                  r_state    <= S_SCALE;
                  r_cnt      <= '0;
                  o_rd_en    <= 1'b1;
                  o_scale_en <= 1'b1;
                  {o_rd_addr_a, o_rd_addr_b, o_zeta_idx} <= f_issue(1'b1, 1'b1, r_lyr, 7'd0);
               end else begin
                  r_state <= S_FIN;
                  o_done  <= 1'b1;
                  o_busy  <= 1'b0;
               end
            end
            S_SCALE: begin
               if (r_cnt == 7'd127) begin
                  r_state    <= S_SDRAIN;
                  r_tmr      <= DRAIN_LD;
                  o_scale_en <= 1'b0;
               end else begin
                  r_cnt   <= r_cnt + 7'd1;
                  o_rd_en <= 1'b1;
                  {o_rd_addr_a, o_rd_addr_b, o_zeta_idx} <= f_issue(1'b1, 1'b1, r_lyr, r_cnt + 7'd1);
               end
            end
            S_SDRAIN: begin
               if (r_tmr != 4'd0) begin
                  r_tmr <= r_tmr - 4'd1;
               end else begin
                  r_state <= S_FIN;
                  o_done  <= 1'b1;
                  o_busy  <= 1'b0;
               end
            end
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // write-back delay line runs regardless of state so in-flight writes always land
   logic [BFLAT-1:0]  r_wen;
   logic [ADDWID-1:0] r_wa [BFLAT];
   logic [ADDWID-1:0] r_wb [BFLAT];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wen <= '0;
         for (int i = 0; i < BFLAT; i++) begin
            r_wa[i] <= '0;
            r_wb[i] <= '0;
         end
      end else begin
         r_wen[0] <= o_rd_en;
         r_wa[0]  <= o_rd_addr_a;
         r_wb[0]  <= o_rd_addr_b;
         for (int i = 1; i < BFLAT; i++) begin
            r_wen[i] <= r_wen[i-1];
            r_wa[i]  <= r_wa[i-1];
            r_wb[i]  <= r_wb[i-1];
         end
      end
   end

   assign o_wr_en     = r_wen[BFLAT-1];
   assign o_wr_addr_a = r_wa[BFLAT-1];
   assign o_wr_addr_b = r_wb[BFLAT-1];

endmodule

// File: tb/tb_polyunit_ntt_sched.sv
// Scoreboard bench for polyunit_ntt_sched: Kyber reference loops feed an expected-issue
// queue; a negedge monitor checks issues, write-backs, busy and done. Two extra BFLAT variants.
module tb_polyunit_ntt_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] mode = 2'b00;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [6:0] z;
      logic       gs;
      logic       sc;
   } iss_t;

   typedef struct {
      int t;
      int a;
      int b;
   } wexp_t;

   iss_t  exp_rd[$];
   wexp_t exp_wr[$];

   int n_cmp = 0;
   int n_bad = 0;
   int exp_done = -1;
   int op_t0 = 0;
   bit op_active = 1'b0;
   int exp_vdone[3];
   int rd_cnt = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int n_ops = 0;

   logic       rd_en [3];
   logic [7:0] ra [3];
   logic [7:0] rb [3];
   logic [6:0] zi [3];
   logic       gs [3];
   logic       sc [3];
   logic       wr_en [3];
   logic [7:0] wa [3];
   logic [7:0] wb [3];
   logic       busy [3];
   logic       done [3];

   function automatic int blat(input int g);
      return (g == 0) ? 4 : ((g == 1) ? 1 : 15);
   endfunction

   function automatic void check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int B = (g == 0) ? 4 : ((g == 1) ? 1 : 15);
      polyunit_ntt_sched #(.ADDWID(8), .ZWID(7), .BFLAT(B)) u_dut (
         .i_clk      (clk),
         .i_rst_n    (rst_n),
         .i_start    (start),
         .i_mode     (mode),
         .o_rd_en    (rd_en[g]),
         .o_rd_addr_a(ra[g]),
         .o_rd_addr_b(rb[g]),
         .o_zeta_idx (zi[g]),
         .o_bf_gs    (gs[g]),
         .o_scale_en (sc[g]),
         .o_wr_en    (wr_en[g]),
         .o_wr_addr_a(wa[g]),
         .o_wr_addr_b(wb[g]),
         .o_busy     (busy[g]),
         .o_done     (done[g])
      );

      // read-after-write hazard tracker: an address may only be read once its last write landed
      int pend [256];
      int hazards = 0;
      int done_err = 0;
      int done_seen = 0;

      always @(negedge clk) begin
         if (!rst_n) begin
            foreach (pend[i]) pend[i] = 0;
         end else begin
            if (rd_en[g]) begin
               if (pend[ra[g]] != 0 || pend[rb[g]] != 0) hazards++;
               if (wr_en[g] && (wa[g] == ra[g] || wa[g] == rb[g] || wb[g] == ra[g] || wb[g] == rb[g]))
                  hazards++;
            end
            if (wr_en[g]) begin
               pend[wa[g]]--;
               pend[wb[g]]--;
            end
            if (rd_en[g]) begin
               pend[ra[g]]++;
               pend[rb[g]]++;
            end
            if (done[g]) begin
               done_seen++;
               if (cyc != exp_vdone[g]) done_err++;
            end
         end
      end
   end

   // main scoreboard monitor, instance 0 (BFLAT=4)
   always @(negedge clk) begin
      iss_t  e;
      wexp_t w;
      bit    eb;
      if (!rst_n) begin
         exp_rd.delete();
         exp_wr.delete();
      end else begin
         eb = op_active && (cyc > op_t0) && (cyc < exp_done);
         check("busy", int'(busy[0]), int'(eb));
         if (wr_en[0]) begin
            wr_cnt++;
            if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
            else begin
               w = exp_wr.pop_front();
               check("wr_cycle", cyc, w.t);
               check("wr_addr_a", int'(wa[0]), w.a);
               check("wr_addr_b", int'(wb[0]), w.b);
            end
         end
         if (rd_en[0]) begin
            rd_cnt++;
            if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
            else begin
               e = exp_rd.pop_front();
               check("rd_addr_a", int'(ra[0]), int'(e.a));
               check("rd_addr_b", int'(rb[0]), int'(e.b));
               check("zeta_idx", int'(zi[0]), int'(e.z));
               check("bf_gs", int'(gs[0]), int'(e.gs));
               check("scale_en", int'(sc[0]), int'(e.sc));
               exp_wr.push_back('{cyc + 4, int'(e.a), int'(e.b)});
            end
         end
         if (done[0]) begin
            done_cnt++;
            check("done_cycle", cyc, exp_done);
            check("rd_queue_left", exp_rd.size(), 0);
            check("wr_queue_left", exp_wr.size(), 0);
         end
      end
   end

   function automatic iss_t mk(input int a, input int b, input int z, input bit g, input bit s);
      iss_t r;
      r.a  = 8'(a);
      r.b  = 8'(b);
      r.z  = 7'(z);
      r.gs = g;
      r.sc = s;
      return r;
   endfunction

   // Kyber reference loop order: one zeta per group, consumed in k order
   task automatic push_model(input bit intt);
      int k;
      if (!intt) begin
         k = 1;
         for (int len = 128; len >= 2; len = len / 2)
            for (int st = 0; st < 256; st += 2 * len) begin
               for (int j = st; j < st + len; j++) exp_rd.push_back(mk(j, j + len, k, 1'b0, 1'b0));
               k++;
            end
      end else begin
         k = 127;
         for (int len = 2; len <= 128; len = len * 2)
            for (int st = 0; st < 256; st += 2 * len) begin
               for (int j = st; j < st + len; j++) exp_rd.push_back(mk(j, j + len, k, 1'b1, 1'b0));
               k--;
            end
         for (int j = 0; j < 128; j++) exp_rd.push_back(mk(j, j + 128, 0, 1'b1, 1'b1));
      end
   endtask

   task automatic start_op(input bit intt, output int t0);
      int nl;
      @(negedge clk);
      push_model(intt);
      nl        = intt ? 8 : 7;
      start     = 1'b1;
      mode      = intt ? 2'b11 : 2'b01;
      t0        = cyc;
      op_t0     = t0;
      op_active = 1'b1;
      exp_done  = t0 + 1 + nl * (128 + 4);
      for (int g = 0; g < 3; g++) exp_vdone[g] = t0 + 1 + nl * (128 + blat(g));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_op(input bit intt, input int bogus);
      int t0, dc0, rd0, wr0;
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      dc0 = done_cnt;
      start_op(intt, t0);
      while (done_cnt == dc0 && cyc < exp_done + 40) begin
         @(negedge clk);
         start = (bogus > 0) && (cyc == t0 + bogus);
         mode  = 2'($urandom_range(0, 3));
      end
      start = 1'b0;
      check("done_seen", done_cnt - dc0, 1);
      check("rd_total", rd_cnt - rd0, intt ? 1024 : 896);
      check("wr_total", wr_cnt - wr0, intt ? 1024 : 896);
      repeat (150) @(negedge clk);
      n_ops++;
   endtask

   task automatic check_reset_outputs();
      for (int g = 0; g < 3; g++) begin
         check("rst_rd_en", int'(rd_en[g]), 0);
         check("rst_wr_en", int'(wr_en[g]), 0);
         check("rst_busy", int'(busy[g]), 0);
         check("rst_done", int'(done[g]), 0);
      end
      check("rst_addrs", int'({ra[0], rb[0], wa[0], wb[0]}), 0);
      check("rst_zeta", int'(zi[0]), 0);
      check("rst_gs_scale", int'({gs[0], sc[0]}), 0);
   endtask

   initial begin
      int t0, rd0, wr0;
      for (int g = 0; g < 3; g++) exp_vdone[g] = -1;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      #2 rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rd0   = rd_cnt;
         start = 1'b1;
         mode  = {1'($urandom_range(0, 1)), 1'b0};
         @(negedge clk);
         start = 1'b0;
         repeat (10) @(negedge clk);
         check("illegal_busy", int'(busy[0]), 0);
         check("illegal_rd", rd_cnt - rd0, 0);
      end

      run_op(1'b0, 300);
      run_op(1'b1, $urandom_range(2, 1000));

      start_op(1'b0, t0);
      while (cyc < t0 + 200) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      op_active = 1'b0;
      exp_done  = -1;
      for (int g = 0; g < 3; g++) exp_vdone[g] = -1;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      wr0 = wr_cnt;
      repeat (30) @(negedge clk);
      check("wr_after_reset", wr_cnt - wr0, 0);
      check("busy_after_reset", int'(busy[0]), 0);

      run_op(1'b0, 0);
      run_op(1'($urandom_range(0, 1)), $urandom_range(2, 900));

      check("hazards_b4", g_dut[0].hazards, 0);
      check("hazards_b1", g_dut[1].hazards, 0);
      check("hazards_b15", g_dut[2].hazards, 0);
      check("done_time_b4", g_dut[0].done_err, 0);
      check("done_time_b1", g_dut[1].done_err, 0);
      check("done_time_b15", g_dut[2].done_err, 0);
      check("done_count_b4", g_dut[0].done_seen, n_ops);
      check("done_count_b1", g_dut[1].done_seen, n_ops);
      check("done_count_b15", g_dut[2].done_seen, n_ops);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/polyunit_ntt_sched.md
# polyunit_ntt_sched

Butterfly scheduler for the Kyber polynomial unit. On a start command it sequences a full 256-point forward NTT or inverse NTT over the coefficient RAM. For each operation it produces:
- the dual-port read addresses,
- the twiddle (zeta) index,
- the butterfly type,
- the delayed write-back addresses matched to the butterfly pipeline latency.

It sits between the top-level command FSM and the butterfly datapath/RAM, and reports completion with a one-cycle done pulse.

## Interface
- ADDWID, 8, coefficient RAM address width (256 coefficients)
- ZWID, 7, zeta index width (indices 1..127)
- BFLAT, 4, butterfly datapath latency in cycles from read issue to write-back (legal range 1..15)

- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  single-cycle command strobe, sampled in IDLE only
- mode  input  2  01 = NTT, 11 = INTT; 00 and 10 make start ignored
- rd_en  output  1  butterfly issue; RAM reads both addresses this cycle
- rd_addr_a  output  ADDWID  upper-half-free operand address j
- rd_addr_b  output  ADDWID  partner address j+len
- zeta_idx  output  ZWID  twiddle ROM index for this issue
- bf_gs  output  1  0 = Cooley-Tukey butterfly, 1 = Gentleman-Sande butterfly
- scale_en  output  1  issue belongs to the INTT final scaling pass (datapath multiplies both operands by f)
- wr_en  output  1  write-back strobe, equal to rd_en delayed by BFLAT
- wr_addr_a  output  ADDWID  rd_addr_a delayed by BFLAT
- wr_addr_b  output  ADDWID  rd_addr_b delayed by BFLAT
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DRAIN, SCALE, SDRAIN, FIN.
- IDLE:
  - If start=1 and mode is 01 or 11: latch mode, clear the layer counter l and the issue counter c, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - One issue per cycle, with c counting 0..127.
  - len = 128>>l for NTT and 2<<l for INTT.
  - grp = c/len, off = c%len.
  - rd_addr_a = 2·len·grp + off; rd_addr_b = rd_addr_a + len.
  - zeta_idx:
    - NTT: (1<<l) + grp.
    - INTT: (256/len − 1) − grp.
  - bf_gs = mode[1].
  - At c=127, go to DRAIN.
- DRAIN:
  - Wait BFLAT cycles with no issues, so the last write of the layer lands before the next layer reads.
  - If l<6: increment l, clear c, go to RUN.
  - If l=6 and NTT: go to FIN.
  - If l=6 and INTT: go to SCALE.
- SCALE (INTT only):
  - 128 issues with rd_addr_a=c, rd_addr_b=c+128, scale_en=1, zeta_idx=0.
  - Then go to SDRAIN.
- SDRAIN: BFLAT idle cycles, then go to FIN.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- Write-back pipeline: a BFLAT-deep shift register of {rd_en, rd_addr_a, rd_addr_b}. It is independent of state and always drains.
- start while busy is ignored, and mode changes while busy are ignored.
- Reset (asynchronous, any time): state → IDLE. All outputs are 0, including wr_en, addresses, zeta_idx, bf_gs, scale_en, busy and done. The write pipeline is cleared, so no stray writes occur after reset release.

## Timing
- All outputs are registered.
- start is sampled at cycle 0; the first rd_en is at cycle 1.
- Each layer takes 128 issue cycles plus BFLAT drain cycles.
- NTT: done at cycle 1 + 7·(128+BFLAT). With BFLAT=4 this is cycle 925.
- INTT: done at cycle 1 + 8·(128+BFLAT). With BFLAT=4 this is cycle 1057.
- wr_en/wr_addr_* at cycle t+BFLAT equal rd_en/rd_addr_* at cycle t.
- The last wr_en precedes done by exactly 1 cycle.
- busy rises in cycle 1 and falls in the done cycle. A new start is accepted in the cycle after done.
- The RAM is required to be read-after-write safe across consecutive cycles. The scheduler never reads an address in the same cycle it writes it.

## Test plan
- NTT, BFLAT=4, layer 0:
  - Issue c=0 → a=0, b=128, zeta=1.
  - c=127 → a=127, b=255, zeta=1.
  - Issue c=0 writes back with wr_en at cycle 5.
- NTT layer 6 (len 2):
  - c=0 → (0,2,z=64); c=1 → (1,3,z=64); c=2 → (4,6,z=65); c=127 → (253,255,z=127).
  - done is at cycle 925; exactly 896 rd_en and 896 wr_en in total.
- INTT:
  - Layer 0: c=0 → (0,2,z=127), bf_gs=1.
  - Layer 6: c=0 → (0,128,z=1).
  - Scale pass: c=5 → (5,133), scale_en=1.
  - done is at cycle 1057; 1024 issues in total.
- start with mode=00 or mode=10 → busy stays 0, no rd_en, no done.
  - start asserted at cycle 300 of a running NTT → no effect, and done still arrives at 925.
- rst low at cycle 200 of an NTT → all outputs are 0 immediately and no wr_en occurs after release.
  - A fresh start then completes normally at +925 cycles.
- BFLAT=1 and BFLAT=15 variants → layer spacing becomes 129 and 143 cycles respectively.
  - No read of an address occurs before its previous-layer write.
